rca_result_buffer: RTL and testbench

Registered result stage directly downstream of the 4-bit ripple-carry adder. It captures the adder's combinational 4-bit sum and carry-out on a valid/ready handshake and holds the results in a small in-order FIFO. It presents them to the next consumer with its own valid/ready handshake. It also keeps a saturating count of results that carried out, for overflow monitoring.

---
 rtl/rca_pkg.sv | 11 +
 rtl/rca_result_fifo.sv | 68 ++++++
 rtl/rca_result_buffer.sv | 75 +++++++
 tb/tb_rca_result_buffer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared ripple-carry adder result width and packed result type
package rca_pkg;

    localparam int RCA_W = 4;

    typedef struct packed {
        logic             cout;
        logic [RCA_W-1:0] sum;
    } rca_result_t;

endpackage

// File: rtl/rca_result_fifo.sv
// rtl/rca_result_fifo.sv - in-order result storage with pointers and occupancy count
module rca_result_fifo
    import rca_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = rca_result_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output T     rd_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head entry is always shown; it reads as zero after reset because storage is cleared.
    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/rca_result_buffer.sv
// rtl/rca_result_buffer.sv - registered adder result stage with handshakes and saturating overflow count
module rca_result_buffer
    import rca_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OVF_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RCA_W-1:0] sum_in,
    input  logic             cout_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RCA_W-1:0] res_sum,
    output logic             res_cout,
    output logic [OVF_W-1:0] ovf_count,
    input  logic             clr_ovf
);

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    rca_result_t wr_data;
    rca_result_t rd_data;
    logic [OVF_W-1:0] ovf_q, ovf_d;

    // in_ready depends only on registered occupancy; a pop while full frees
    // the slot for the following cycle, never the same one.
    assign in_ready  = !full;
    assign res_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = res_valid && res_ready;
    assign wr_data   = '{cout: cout_in, sum: sum_in};

    rca_result_fifo #(
        .DEPTH (DEPTH),
        .T     (rca_result_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    assign res_sum  = rd_data.sum;
    assign res_cout = rd_data.cout;

    // Clear has priority over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = '0;
        end else if (push && cout_in && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_count = ovf_q;

endmodule

// File: tb/tb_rca_result_buffer.sv
// tb/tb_rca_result_buffer.sv - table-driven and scoreboard bench for rca_result_buffer
module tb_rca_result_buffer;

    localparam int DEPTH = 2;
    localparam int OVF_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       sum_in;
    logic             cout_in;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_sum;
    logic             res_cout;
    logic [OVF_W-1:0] ovf_count;
    logic             clr_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] sb [$];

    typedef struct {
        logic       iv;
        logic [3:0] s;
        logic       c;
        logic       rr;
        logic       clr;
        logic       eir;
        logic       erv;
        int         eovf;
    } vec_t;

    vec_t tbl [16];

    rca_result_buffer #(
        .DEPTH (DEPTH),
        .OVF_W (OVF_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .cout_in   (cout_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .ovf_count (ovf_count),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then update the scoreboard
    // with what the coming edge should accept and deliver.
    task automatic step(input logic iv, input logic [3:0] s, input logic c,
                        input logic rr, input logic clr, input logic eir,
                        input logic erv, input int eovf, input bit chk_ovf);
        logic [4:0] head;
        @(negedge clk);
        in_valid  = iv;
        sum_in    = s;
        cout_in   = c;
        res_ready = rr;
        clr_ovf   = clr;
        #1;
        chk("in_ready", int'(in_ready), int'(eir));
        chk("res_valid", int'(res_valid), int'(erv));
        if (chk_ovf) chk("ovf_count", int'(ovf_count), eovf);
        if (erv) begin
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else begin
                head = sb[0];
                chk("res_data", int'({res_cout, res_sum}), int'(head));
            end
        end
        if (rr && erv && sb.size() != 0) void'(sb.pop_front());
        if (iv && eir) sb.push_back({c, s});
    endtask

    initial begin
        logic [3:0] rs;
        logic       rc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sum_in    = 4'h0;
        cout_in   = 1'b0;
        res_ready = 1'b0;
        clr_ovf   = 1'b0;

        //            iv  s     c  rr clr eir erv ovf
        tbl[0]  = '{1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[3]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[4]  = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[5]  = '{1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[7]  = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2};
        tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[10] = '{1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2};
        tbl[11] = '{1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3};
        tbl[12] = '{1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3};
        tbl[13] = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3};
        tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        tbl[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};

        @(negedge clk);
        @(negedge clk);
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_res_sum", int'(res_sum), 0);
        chk("reset_ovf", int'(ovf_count), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].iv, tbl[i].s, tbl[i].c, tbl[i].rr, tbl[i].clr,
                 tbl[i].eir, tbl[i].erv, tbl[i].eovf, 1'b1);
        end
        chk("table_sb_empty", sb.size(), 0);

        // Sustained push and pop at occupancy 1.
        step(1'b1, 4'(($urandom)), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            rs = 4'($urandom);
            rc = 1'($urandom);
            step(1'b1, rs, rc, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
            chk("stream_occupancy", sb.size(), 1);
        end
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);

        // Reset with two entries held and a nonzero overflow count.
        step(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("pre_reset_full", int'(in_ready), 0);
        chk("pre_reset_ovf", int'(ovf_count), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_res_valid", int'(res_valid), 0);
        chk("async_reset_in_ready", int'(in_ready), 1);
        chk("async_reset_ovf", int'(ovf_count), 0);
        chk("async_reset_res_sum", int'(res_sum), 0);
        chk("async_reset_res_cout", int'(res_cout), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        chk("post_reset_res_sum", int'(res_sum), 0);
        step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
